dma_ctrl_multi: RTL and testbench
=================================

// Module: dma_ctrl_multi
// PURPOSE
//  Register-mapped DMA job controller for N_MM2S read channels plus one S2MM write channel.
//  Sits between the AXI-Lite register bridge and the alex_axi_dma_rd/wr engines in sys top.
//  Issues one descriptor per enabled channel per job and tracks completion per channel.
//  Latches errors and raises a level interrupt on job completion.
// PARAMETERS
//  N_MM2S          2   number of MM2S read channels (1..8)
//  AXI_ADDR_WIDTH  32  descriptor address width (A)
//  AXI_LEN_WIDTH   32  descriptor byte-length width (L)
//  AXIS_USER_WIDTH 8   MM2S descriptor tuser width (U)
//  TAG_WIDTH       8   S2MM descriptor tag width
//  REG_DATA_WIDTH  32  register data width (>= A, L, U)
// PORTS
//  clk                 in  1          clock
//  rstn                in  1          async active-low reset
//  reg_wr_en           in  1          register write strobe
//  reg_wr_addr         in  A          register word index
//  reg_wr_data         in  32         register write data
//  reg_rd_en           in  1          register read strobe
//  reg_rd_addr         in  A          register word index
//  reg_rd_data         out 32         read data, registered
//  s2mm_desc           out A+L        {len,addr}; addr in [A-1:0]
//  s2mm_tag            out TAG_WIDTH  job number, low bits
//  s2mm_valid/ready    out/in 1       S2MM descriptor handshake
//  s2mm_status_error   in  4          S2MM completion error code
//  s2mm_status_valid   in  1          S2MM completion pulse
//  mm2s_desc           out N*(A+L)    per-channel {len,addr}; ch i at slice i
//  mm2s_user           out N*U        per-channel tuser
//  mm2s_valid/ready    out/in N       per-channel descriptor handshake
//  mm2s_status_error   in  N*4        per-channel completion error code
//  mm2s_status_valid   in  N          per-channel completion pulse
//  irq                 out 1          DONE & IRQ_EN
// BEHAVIOUR
//  Register map (word index):
//   0 CTRL: b0 START (write-1 pulse), b1 IRQ_EN
//   1 STATUS: b0 BUSY, b1 DONE, b2 ERR; writing 1 to b1/b2 clears that bit
//   2 ERR_CODE: {ch[3:0], code[3:0]}; ch=0xF is S2MM
//   3 CYCLES
//   4 S2MM_ADDR    5 S2MM_LEN    6 JOB_COUNT (RO)
//   8+4i MM2S_ADDR_i    9+4i MM2S_LEN_i    10+4i MM2S_USER_i
//   Unmapped reads return 0; unmapped writes are ignored.
//  Reset: all registers, outputs, valids and irq are 0; state is IDLE.
//  Read: reg_rd_data is updated the cycle after reg_rd_en and holds its value otherwise.
//  FSM:
//   IDLE  -> ISSUE on START; ignored when BUSY=1.
//            On entry: clear DONE and ERR; snapshot channel regs;
//            set pending[ch] = (LEN != 0); BUSY=1.
//   ISSUE -> Assert valid on every pending channel in the same cycle.
//            Each valid drops independently after its own valid&ready; desc is stable while valid.
//            -> WAIT once every valid has handshaked.
//   WAIT  -> Stay until every pending channel has returned status_valid.
//            status_valid is also accepted in ISSUE, once that channel's descriptor has handshaked.
//            Simultaneous status pulses from several channels are all captured in the same cycle.
//   DONE  -> One cycle: DONE=1, BUSY=0, JOB_COUNT++ (wraps), then IDLE.
//  Zero-length channels: no descriptor is issued; the channel counts as complete.
//   All LEN=0: job passes through ISSUE->WAIT->DONE in 3 cycles.
//  Errors: nonzero status_error sets ERR.
//   ERR_CODE records the first error only; for same-cycle errors the lowest MM2S index wins, S2MM last.
//  s2mm_tag = JOB_COUNT[TAG_WIDTH-1:0] at START.
//  Register writes during BUSY update the shadow registers only; the running job is unaffected.
//  Async reset mid-job: immediate return to IDLE with valids low.
//   The engines must be reset together with this block.
// CONFIGURATION
//  DMA_CTRL_PERF_EN defined:
//   CYCLES clears at START and increments every cycle BUSY=1; it saturates at all-ones.
//  Not defined: CYCLES reads 0; no counter logic is built.
// TESTING
//  N=2; ch0 0x1000/64, ch1 0x2000/32, s2mm 0x3000/16; START; ready=1; status after 5 cycles
//   -> three valids high 1 cycle, DONE=1 after last status, JOB_COUNT=1, irq=IRQ_EN.
//  ch1 LEN=0 -> mm2s_valid[1] never asserts; DONE follows ch0 and S2MM status only.
//  ch0 ready held low 10 cycles, ch1 ready=1, ch1 status arrives during ISSUE
//   -> ch1 status captured; ch0 desc stable until its handshake; DONE after ch0 status.
//  ch1 error=2 and S2MM error=3 in the same cycle -> ERR=1, ERR_CODE=0x12; DONE still set.
//  START written while BUSY; async rstn pulse in WAIT
//   -> second START ignored, JOB_COUNT +1 only; after reset all outputs 0, IDLE, BUSY=0.
//  With DMA_CTRL_PERF_EN, 20-cycle job -> CYCLES=20; without it -> CYCLES reads 0.

Source files
------------

// File: rtl/dma_ctrl_multi_if.sv
// Register bus and descriptor/status channels of dma_ctrl_multi.
// master = the controller, slave = register bridge plus DMA engines.
interface dma_ctrl_multi_if #(
    parameter int unsigned N_MM2S          = 2,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_LEN_WIDTH   = 32,
    parameter int unsigned AXIS_USER_WIDTH = 8,
    parameter int unsigned TAG_WIDTH       = 8,
    parameter int unsigned REG_DATA_WIDTH  = 32
);
    localparam int unsigned DW = AXI_ADDR_WIDTH + AXI_LEN_WIDTH;

    logic                              reg_wr_en;
    logic [AXI_ADDR_WIDTH-1:0]         reg_wr_addr;
    logic [REG_DATA_WIDTH-1:0]         reg_wr_data;
    logic                              reg_rd_en;
    logic [AXI_ADDR_WIDTH-1:0]         reg_rd_addr;
    logic [REG_DATA_WIDTH-1:0]         reg_rd_data;

    logic [DW-1:0]                     s2mm_desc;
    logic [TAG_WIDTH-1:0]              s2mm_tag;
    logic                              s2mm_valid;
    logic                              s2mm_ready;
    logic [3:0]                        s2mm_status_error;
    logic                              s2mm_status_valid;

    logic [N_MM2S*DW-1:0]              mm2s_desc;
    logic [N_MM2S*AXIS_USER_WIDTH-1:0] mm2s_user;
    logic [N_MM2S-1:0]                 mm2s_valid;
    logic [N_MM2S-1:0]                 mm2s_ready;
    logic [N_MM2S*4-1:0]               mm2s_status_error;
    logic [N_MM2S-1:0]                 mm2s_status_valid;

    logic                              irq;

    modport master (
        input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
        input  s2mm_ready, s2mm_status_error, s2mm_status_valid,
        input  mm2s_ready, mm2s_status_error, mm2s_status_valid,
        output reg_rd_data, s2mm_desc, s2mm_tag, s2mm_valid,
        output mm2s_desc, mm2s_user, mm2s_valid, irq
    );

    modport slave (
        output reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
        output s2mm_ready, s2mm_status_error, s2mm_status_valid,
        output mm2s_ready, mm2s_status_error, mm2s_status_valid,
        input  reg_rd_data, s2mm_desc, s2mm_tag, s2mm_valid,
        input  mm2s_desc, mm2s_user, mm2s_valid, irq
    );
endinterface

// File: rtl/dma_ctrl_multi.sv
// Register-mapped DMA job controller: N_MM2S read channels plus one S2MM write channel.
// Define DMA_CTRL_PERF_EN to build the saturating CYCLES job-duration counter.
module dma_ctrl_multi #(
    parameter int unsigned N_MM2S          = 2,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_LEN_WIDTH   = 32,
    parameter int unsigned AXIS_USER_WIDTH = 8,
    parameter int unsigned TAG_WIDTH       = 8,
    parameter int unsigned REG_DATA_WIDTH  = 32
) (
    input logic              clk_i,
    input logic              rstn_i,
    dma_ctrl_multi_if.master bus_io
);
    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned LW = AXI_LEN_WIDTH;
    localparam int unsigned UW = AXIS_USER_WIDTH;
    localparam int unsigned DW = AW + LW;
    localparam int unsigned RW = REG_DATA_WIDTH;
    localparam int unsigned NC = N_MM2S + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic                            irq_en_q, done_q, done_d, err_q, err_d;
    logic [7:0]                      err_code_q, err_code_d, err_code_new;
    logic [RW-1:0]                   job_count_q, rd_data_q, rd_val, cycles;
    logic [AW-1:0]                   s2mm_addr_q;
    logic [LW-1:0]                   s2mm_len_q;
    logic [N_MM2S-1:0][AW-1:0]       mm2s_addr_q;
    logic [N_MM2S-1:0][LW-1:0]       mm2s_len_q;
    logic [N_MM2S-1:0][UW-1:0]       mm2s_user_q, mm2s_uout_q;
    logic [N_MM2S-1:0][DW-1:0]       mm2s_desc_q;
    logic [DW-1:0]                   s2mm_desc_q;
    logic [TAG_WIDTH-1:0]            tag_q;
    // Channel vectors: bits [N_MM2S-1:0] are MM2S, bit N_MM2S is S2MM.
    logic [NC-1:0]                   valid_q, valid_d, pend_q, pend_d;
    logic [NC-1:0]                   len_nz, ready, stat_v, acc;
    logic [NC-1:0][3:0]              stat_err;
    logic                            busy, launch, enter_done, err_found;

    assign busy   = (state_q == StIssue) || (state_q == StWait);
    assign launch = bus_io.reg_wr_en && (bus_io.reg_wr_addr == AW'(0)) &&
                    bus_io.reg_wr_data[0] && !busy;

    always_comb begin
        for (int i = 0; i < N_MM2S; i++) begin
            ready[i]    = bus_io.mm2s_ready[i];
            stat_v[i]   = bus_io.mm2s_status_valid[i];
            stat_err[i] = bus_io.mm2s_status_error[4*i +: 4];
            len_nz[i]   = (mm2s_len_q[i] != '0);
        end
        ready[N_MM2S]    = bus_io.s2mm_ready;
        stat_v[N_MM2S]   = bus_io.s2mm_status_valid;
        stat_err[N_MM2S] = bus_io.s2mm_status_error;
        len_nz[N_MM2S]   = (s2mm_len_q != '0);
    end

    // Status counts only after the channel's own descriptor has handshaked.
    assign acc = stat_v & pend_q & ~valid_q & {NC{busy}};

    always_comb begin
        state_d = state_q;
        valid_d = valid_q & ~ready;
        pend_d  = pend_q & ~acc;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (launch) begin
                    state_d = StIssue;
                    valid_d = len_nz;
                    pend_d  = len_nz;
                end
            end
            StIssue: if ((valid_q & ~ready) == '0) state_d = StWait;
            StWait:  if (pend_d == '0) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    assign enter_done = (state_q == StWait) && (pend_d == '0);

    // Lowest MM2S index wins among same-cycle errors; S2MM has lowest priority.
    always_comb begin
        err_found    = 1'b0;
        err_code_new = '0;
        for (int i = 0; i < N_MM2S; i++) begin
            if (!err_found && acc[i] && stat_err[i] != 4'd0) begin
                err_found    = 1'b1;
                err_code_new = {4'(i), stat_err[i]};
            end
        end
        if (!err_found && acc[N_MM2S] && stat_err[N_MM2S] != 4'd0) begin
            err_found    = 1'b1;
            err_code_new = {4'hF, stat_err[N_MM2S]};
        end
    end

    always_comb begin
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (bus_io.reg_wr_en && bus_io.reg_wr_addr == AW'(1)) begin
            if (bus_io.reg_wr_data[1]) done_d = 1'b0;
            if (bus_io.reg_wr_data[2]) err_d = 1'b0;
        end
        if (launch) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (enter_done) done_d = 1'b1;
        if (err_found) begin
            err_d = 1'b1;
            if (!err_q) err_code_d = err_code_new;
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus_io.reg_rd_addr)
            AW'(0): rd_val[1]   = irq_en_q;
            AW'(1): rd_val[2:0] = {err_q, done_q, busy};
            AW'(2): rd_val[7:0] = err_code_q;
            AW'(3): rd_val      = cycles;
            AW'(4): rd_val      = RW'(s2mm_addr_q);
            AW'(5): rd_val      = RW'(s2mm_len_q);
            AW'(6): rd_val      = job_count_q;
            default: begin
                for (int i = 0; i < N_MM2S; i++) begin
                    if (bus_io.reg_rd_addr == AW'(8 + 4 * i))  rd_val = RW'(mm2s_addr_q[i]);
                    if (bus_io.reg_rd_addr == AW'(9 + 4 * i))  rd_val = RW'(mm2s_len_q[i]);
                    if (bus_io.reg_rd_addr == AW'(10 + 4 * i)) rd_val = RW'(mm2s_user_q[i]);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            pend_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            job_count_q <= '0;
            rd_data_q   <= '0;
            s2mm_desc_q <= '0;
            tag_q       <= '0;
            mm2s_desc_q <= '0;
            mm2s_uout_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            if (enter_done) job_count_q <= job_count_q + 1'b1;
            if (bus_io.reg_rd_en) rd_data_q <= rd_val;
            if (launch) begin
                s2mm_desc_q <= {s2mm_len_q, s2mm_addr_q};
                tag_q       <= job_count_q[TAG_WIDTH-1:0];
                for (int i = 0; i < N_MM2S; i++) begin
                    mm2s_desc_q[i] <= {mm2s_len_q[i], mm2s_addr_q[i]};
                    mm2s_uout_q[i] <= mm2s_user_q[i];
                end
            end
        end
    end

    // Shadow registers: always writable, consumed only at job launch.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_en_q    <= 1'b0;
            s2mm_addr_q <= '0;
            s2mm_len_q  <= '0;
            mm2s_addr_q <= '0;
            mm2s_len_q  <= '0;
            mm2s_user_q <= '0;
        end else if (bus_io.reg_wr_en) begin
            if (bus_io.reg_wr_addr == AW'(0)) irq_en_q <= bus_io.reg_wr_data[1];
            if (bus_io.reg_wr_addr == AW'(4)) s2mm_addr_q <= bus_io.reg_wr_data[AW-1:0];
            if (bus_io.reg_wr_addr == AW'(5)) s2mm_len_q <= bus_io.reg_wr_data[LW-1:0];
            for (int i = 0; i < N_MM2S; i++) begin
                if (bus_io.reg_wr_addr == AW'(8 + 4 * i))
                    mm2s_addr_q[i] <= bus_io.reg_wr_data[AW-1:0];
                if (bus_io.reg_wr_addr == AW'(9 + 4 * i))
                    mm2s_len_q[i] <= bus_io.reg_wr_data[LW-1:0];
                if (bus_io.reg_wr_addr == AW'(10 + 4 * i))
                    mm2s_user_q[i] <= bus_io.reg_wr_data[UW-1:0];
            end
        end
    end

`ifdef DMA_CTRL_PERF_EN
    logic [RW-1:0] cycles_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cycles_q <= '0;
        end else if (launch) begin
            cycles_q <= '0;
        end else if (busy && cycles_q != '1) begin
            cycles_q <= cycles_q + 1'b1;
        end
    end

    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

    assign bus_io.reg_rd_data = rd_data_q;
    assign bus_io.s2mm_desc   = s2mm_desc_q;
    assign bus_io.s2mm_tag    = tag_q;
    assign bus_io.s2mm_valid  = valid_q[N_MM2S];
    assign bus_io.mm2s_desc   = mm2s_desc_q;
    assign bus_io.mm2s_user   = mm2s_uout_q;
    assign bus_io.mm2s_valid  = valid_q[N_MM2S-1:0];
    assign bus_io.irq         = done_q & irq_en_q;
endmodule

// File: tb/tb_dma_ctrl_multi.sv
// Scoreboard bench for dma_ctrl_multi (N_MM2S=2): expected descriptors and register reads are
// queued by the stimulus and popped by a monitor when the DUT presents them.
module tb_dma_ctrl_multi;
    typedef struct {
        logic [63:0] desc;
        logic [7:0]  side;
    } desc_exp_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

`ifdef DMA_CTRL_PERF_EN
    localparam logic [31:0] ExpCycles = 32'd20;
`else
    localparam logic [31:0] ExpCycles = 32'd0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic rd_seen = 1'b0;

    desc_exp_t q0[$];
    desc_exp_t q1[$];
    desc_exp_t qs[$];
    rd_exp_t   rd_q[$];

    dma_ctrl_multi_if bus ();

    dma_ctrl_multi #(.N_MM2S(2)) u_dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endfunction

    function automatic void unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got an unexpected transfer, expected none", nm);
    endfunction

    always @(posedge clk) rd_seen <= bus.reg_rd_en;

    // Monitor: one pop per handshake and per read-data update.
    always @(negedge clk) begin
        desc_exp_t e;
        rd_exp_t   r;
        if (bus.mm2s_valid[0] && bus.mm2s_ready[0]) begin
            if (q0.size() == 0) unexpected("mm2s0_desc");
            else begin
                e = q0.pop_front();
                check("mm2s0_desc", bus.mm2s_desc[63:0], e.desc);
                check("mm2s0_user", 64'(bus.mm2s_user[7:0]), 64'(e.side));
            end
        end
        if (bus.mm2s_valid[1] && bus.mm2s_ready[1]) begin
            if (q1.size() == 0) unexpected("mm2s1_desc");
            else begin
                e = q1.pop_front();
                check("mm2s1_desc", bus.mm2s_desc[127:64], e.desc);
                check("mm2s1_user", 64'(bus.mm2s_user[15:8]), 64'(e.side));
            end
        end
        if (bus.s2mm_valid && bus.s2mm_ready) begin
            if (qs.size() == 0) unexpected("s2mm_desc");
            else begin
                e = qs.pop_front();
                check("s2mm_desc", bus.s2mm_desc, e.desc);
                check("s2mm_tag", 64'(bus.s2mm_tag), 64'(e.side));
            end
        end
        if (rd_seen) begin
            if (rd_q.size() == 0) unexpected("reg_read");
            else begin
                r = rd_q.pop_front();
                check(r.name, 64'(bus.reg_rd_data), 64'(r.val));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.reg_wr_en   = 1'b1;
        bus.reg_wr_addr = 32'(a);
        bus.reg_wr_data = d;
        tick(1);
        bus.reg_wr_en = 1'b0;
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string nm);
        rd_exp_t t;
        t.name = nm;
        t.val  = exp;
        rd_q.push_back(t);
        bus.reg_rd_en   = 1'b1;
        bus.reg_rd_addr = 32'(a);
        tick(1);
        bus.reg_rd_en = 1'b0;
    endtask

    task automatic push_desc(input int ch, input logic [31:0] addr, input logic [31:0] len,
                             input logic [7:0] side);
        desc_exp_t e;
        e.desc = {len, addr};
        e.side = side;
        if (ch == 0) q0.push_back(e);
        else if (ch == 1) q1.push_back(e);
        else qs.push_back(e);
    endtask

    task automatic status(input logic [1:0] mv, input logic [7:0] me, input logic sv,
                          input logic [3:0] se);
        bus.mm2s_status_valid = mv;
        bus.mm2s_status_error = me;
        bus.s2mm_status_valid = sv;
        bus.s2mm_status_error = se;
        tick(1);
        bus.mm2s_status_valid = 2'b00;
        bus.mm2s_status_error = 8'h00;
        bus.s2mm_status_valid = 1'b0;
        bus.s2mm_status_error = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        bus.reg_wr_en = 1'b0;
        bus.reg_wr_addr = '0;
        bus.reg_wr_data = '0;
        bus.reg_rd_en = 1'b0;
        bus.reg_rd_addr = '0;
        bus.s2mm_ready = 1'b0;
        bus.s2mm_status_error = 4'h0;
        bus.s2mm_status_valid = 1'b0;
        bus.mm2s_ready = 2'b00;
        bus.mm2s_status_error = 8'h00;
        bus.mm2s_status_valid = 2'b00;
        #2 rstn = 1'b0;
        tick(3);
        check("rst_valids", 64'({bus.s2mm_valid, bus.mm2s_valid}), 64'd0);
        check("rst_irq", 64'(bus.irq), 64'd0);
        check("rst_rd_data", 64'(bus.reg_rd_data), 64'd0);
        check("rst_s2mm_desc", bus.s2mm_desc, 64'd0);
        rstn = 1'b1;
        bus.mm2s_ready = 2'b11;
        bus.s2mm_ready = 1'b1;
        tick(1);
        rd(1, 32'h0, "rst_status");
        rd(6, 32'h0, "rst_jobs");

        // Job 1: all three channels, immediate ready, status 5 cycles later.
        wr(8, 32'h1000); wr(9, 32'd64); wr(10, 32'h5A);
        wr(12, 32'h2000); wr(13, 32'd32); wr(14, 32'hA5);
        wr(4, 32'h3000); wr(5, 32'd16);
        push_desc(0, 32'h1000, 32'd64, 8'h5A);
        push_desc(1, 32'h2000, 32'd32, 8'hA5);
        push_desc(2, 32'h3000, 32'd16, 8'h00);
        wr(0, 32'h3);
        check("t1_valid_hi", 64'({bus.s2mm_valid, bus.mm2s_valid}), 64'b111);
        tick(1);
        check("t1_valid_lo", 64'({bus.s2mm_valid, bus.mm2s_valid}), 64'b000);
        tick(3);
        status(2'b11, 8'h00, 1'b1, 4'h0);
        check("t1_irq", 64'(bus.irq), 64'd1);
        rd(1, 32'h2, "t1_status");
        rd(6, 32'h1, "t1_jobs");
        rd(14, 32'hA5, "t1_user1");
        rd(7, 32'h0, "t1_unmapped7");
        rd(11, 32'h0, "t1_unmapped11");
        rd(0, 32'h2, "t1_ctrl");

        // Job 2: ch1 length 0 is skipped.
        wr(13, 32'd0);
        push_desc(0, 32'h1000, 32'd64, 8'h5A);
        push_desc(2, 32'h3000, 32'd16, 8'h01);
        wr(0, 32'h3);
        check("t2_irq_cleared", 64'(bus.irq), 64'd0);
        check("t2_valid_hi", 64'({bus.s2mm_valid, bus.mm2s_valid}), 64'b101);
        tick(1);
        status(2'b01, 8'h00, 1'b0, 4'h0);
        rd(1, 32'h1, "t2_busy");
        status(2'b00, 8'h00, 1'b1, 4'h0);
        rd(1, 32'h2, "t2_done");
        rd(6, 32'h2, "t2_jobs");

        // Job 3: ch0 back-pressured 10 cycles, ch1/S2MM status during ISSUE.
        wr(13, 32'd32);
        wr(8, 32'h1100);
        bus.mm2s_ready = 2'b10;
        push_desc(0, 32'h1100, 32'd64, 8'h5A);
        push_desc(1, 32'h2000, 32'd32, 8'hA5);
        push_desc(2, 32'h3000, 32'd16, 8'h02);
        wr(0, 32'h3);
        check("t3_valid_hi", 64'({bus.s2mm_valid, bus.mm2s_valid}), 64'b111);
        tick(1);
        check("t3_valid_ch0", 64'({bus.s2mm_valid, bus.mm2s_valid}), 64'b001);
        status(2'b10, 8'h00, 1'b1, 4'h0);
        wr(8, 32'hDEAD);
        stable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (bus.mm2s_desc[63:0] !== {32'd64, 32'h1100} || bus.mm2s_valid[0] !== 1'b1)
                stable = 1'b0;
        end
        check("t3_desc_stable", 64'(stable), 64'd1);
        bus.mm2s_ready = 2'b11;
        tick(1);
        check("t3_valid_lo", 64'({bus.s2mm_valid, bus.mm2s_valid}), 64'b000);
        tick(2);
        rd(1, 32'h1, "t3_busy");
        status(2'b01, 8'h00, 1'b0, 4'h0);
        rd(1, 32'h2, "t3_done");
        rd(6, 32'h3, "t3_jobs");
        rd(8, 32'hDEAD, "t3_shadow");

        // Job 4: simultaneous errors on ch1 and S2MM.
        push_desc(0, 32'hDEAD, 32'd64, 8'h5A);
        push_desc(1, 32'h2000, 32'd32, 8'hA5);
        push_desc(2, 32'h3000, 32'd16, 8'h03);
        wr(0, 32'h3);
        tick(2);
        status(2'b11, 8'h20, 1'b1, 4'h3);
        rd(1, 32'h6, "t4_status");
        rd(2, 32'h12, "t4_errcode");
        rd(6, 32'h4, "t4_jobs");
        wr(1, 32'h6);
        rd(1, 32'h0, "t4_cleared");
        check("t4_irq_cleared", 64'(bus.irq), 64'd0);

        // Job 5: START while busy is ignored.
        push_desc(0, 32'hDEAD, 32'd64, 8'h5A);
        push_desc(1, 32'h2000, 32'd32, 8'hA5);
        push_desc(2, 32'h3000, 32'd16, 8'h04);
        wr(0, 32'h3);
        tick(1);
        wr(0, 32'h3);
        status(2'b11, 8'h00, 1'b1, 4'h0);
        rd(1, 32'h2, "t5_status");
        rd(6, 32'h5, "t5_jobs");
        tick(3);
        check("t5_no_restart", 64'({bus.s2mm_valid, bus.mm2s_valid}), 64'b000);

        // Job 6: async reset while in WAIT.
        push_desc(0, 32'hDEAD, 32'd64, 8'h5A);
        push_desc(1, 32'h2000, 32'd32, 8'hA5);
        push_desc(2, 32'h3000, 32'd16, 8'h05);
        wr(0, 32'h3);
        tick(2);
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_valids", 64'({bus.s2mm_valid, bus.mm2s_valid}), 64'd0);
        check("t6_rst_irq", 64'(bus.irq), 64'd0);
        check("t6_rst_s2mm_desc", bus.s2mm_desc, 64'd0);
        check("t6_rst_mm2s_desc", bus.mm2s_desc[63:0], 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        tick(1);
        rd(1, 32'h0, "t6_status");
        rd(6, 32'h0, "t6_jobs");
        rd(0, 32'h0, "t6_ctrl");
        rd(8, 32'h0, "t6_addr0");

        // Job 7: 20 busy cycles for the optional counter.
        wr(8, 32'h4000);
        wr(9, 32'd128);
        push_desc(0, 32'h4000, 32'd128, 8'h00);
        wr(0, 32'h1);
        tick(19);
        status(2'b01, 8'h00, 1'b0, 4'h0);
        rd(3, ExpCycles, "t7_cycles");
        tick(3);
        rd(3, ExpCycles, "t7_cycles_hold");
        rd(6, 32'h1, "t7_jobs");

        tick(2);
        check("sb_drained", 64'(q0.size() + q1.size() + qs.size() + rd_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
